// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite widths, bus structs, response/state enums and core-side
// request/response structs used by the load/store and fetch bridges.
package axi4lite_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = 4;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        AXI_IDLE,
        AXI_AR_WAIT,
        AXI_R_WAIT,
        AXI_AW_WAIT,
        AXI_W_WAIT,
        AXI_B_WAIT
    } axi_master_state_e;

    // Master-to-slave: 105 bits.
    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] awaddr;
        logic                      awvalid;
        logic [AXI_DATA_WIDTH-1:0] wdata;
        logic [AXI_STRB_WIDTH-1:0] wstrb;
        logic                      wvalid;
        logic                      bready;
        logic [AXI_ADDR_WIDTH-1:0] araddr;
        logic                      arvalid;
        logic                      rready;
    } axi4lite_m2s_t;

    // Slave-to-master: 41 bits.
    typedef struct packed {
        logic                      awready;
        logic                      wready;
        logic [1:0]                bresp;
        logic                      bvalid;
        logic                      arready;
        logic [AXI_DATA_WIDTH-1:0] rdata;
        logic [1:0]                rresp;
        logic                      rvalid;
    } axi4lite_s2m_t;

    typedef struct packed {
        logic                      we;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_DATA_WIDTH-1:0] wdata;
        logic [AXI_STRB_WIDTH-1:0] wstrb;
    } mem_req_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } mem_resp_t;

    // OKAY/EXOKAY succeed; SLVERR/DECERR fail.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding core load/store port to AXI4-Lite master bridge.
// Optional AXI_ALIGN_CHECK_EN: misaligned requests fail locally, no bus traffic.
module axi4lite_master_bridge
    import axi4lite_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_wstrb,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output axi4lite_m2s_t m_axi_o,
    input  axi4lite_s2m_t m_axi_i
);

    axi_master_state_e r_state, w_next;
    mem_req_t          r_req;
    mem_resp_t         r_resp;
    logic              r_resp_valid;
    logic              r_w_done;

    logic w_accept;
    logic w_misalign;
    logic w_align_hold;
    logic w_rd_done;
    logic w_wr_done;
    logic w_w_early;

`ifdef AXI_ALIGN_CHECK_EN
    logic r_align_err;
    assign w_misalign = w_accept && (req_addr[1:0] != 2'b00);
    always_ff @(posedge clk) begin
        if (rst) r_align_err <= 1'b0;
        else     r_align_err <= w_misalign;
    end
    // Keep the port closed during the local error pulse.
    assign w_align_hold = r_align_err;
`else
    assign w_misalign   = 1'b0;
    assign w_align_hold = 1'b0;
`endif

    assign req_ready = (r_state == AXI_IDLE) && !w_align_hold;
    assign w_accept  = req_valid && req_ready;
    assign w_rd_done = (r_state == AXI_R_WAIT) && m_axi_i.rvalid;
    assign w_wr_done = (r_state == AXI_B_WAIT) && m_axi_i.bvalid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= AXI_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next            = r_state;
        w_w_early         = 1'b0;
        m_axi_o           = '0;
        m_axi_o.awaddr    = r_req.addr;
        m_axi_o.araddr    = r_req.addr;
        m_axi_o.wdata     = r_req.wdata;
        m_axi_o.wstrb     = r_req.wstrb;
        case (r_state)
            AXI_IDLE: begin
                if (w_accept && !w_misalign)
                    w_next = req_we ? AXI_AW_WAIT : AXI_AR_WAIT;
            end
            AXI_AR_WAIT: begin
                m_axi_o.arvalid = 1'b1;
                if (m_axi_i.arready) w_next = AXI_R_WAIT;
            end
            AXI_R_WAIT: begin
                m_axi_o.rready = 1'b1;
                if (m_axi_i.rvalid) w_next = AXI_IDLE;
            end
            AXI_AW_WAIT: begin
                m_axi_o.awvalid = 1'b1;
                m_axi_o.wvalid  = !r_w_done;
                if (m_axi_i.awready) begin
                    if (r_w_done || m_axi_i.wready) w_next = AXI_B_WAIT;
                    else                            w_next = AXI_W_WAIT;
                end else if (!r_w_done && m_axi_i.wready) begin
                    w_w_early = 1'b1;
                end
            end
            AXI_W_WAIT: begin
                m_axi_o.wvalid = 1'b1;
                if (m_axi_i.wready) w_next = AXI_B_WAIT;
            end
            AXI_B_WAIT: begin
                m_axi_o.bready = 1'b1;
                if (m_axi_i.bvalid) w_next = AXI_IDLE;
            end
            default: w_next = AXI_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req        <= '0;
            r_resp       <= '0;
            r_resp_valid <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req.we    <= req_we;
                r_req.addr  <= req_addr;
                r_req.wdata <= req_wdata;
                r_req.wstrb <= req_wstrb;
            end

            if (w_next == AXI_IDLE) r_w_done <= 1'b0;
            else if (w_w_early)     r_w_done <= 1'b1;

            r_resp_valid <= w_rd_done || w_wr_done || w_misalign;
            if (w_rd_done) begin
                r_resp.rdata <= m_axi_i.rdata;
                r_resp.err   <= resp_is_err(m_axi_i.rresp);
            end else if (w_wr_done) begin
                r_resp.rdata <= '0;
                r_resp.err   <= resp_is_err(m_axi_i.bresp);
            end else if (w_misalign) begin
                r_resp.rdata <= '0;
                r_resp.err   <= 1'b1;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp.rdata;
    assign resp_err   = r_resp.err;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Directed bench for axi4lite_master_bridge: cycle-exact slave stimulus,
// outputs sampled on the falling edge.
module tb_axi4lite_master_bridge;
    import axi4lite_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [31:0]   req_addr, req_wdata;
    logic [3:0]    req_wstrb;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    axi4lite_m2s_t m2s;
    axi4lite_s2m_t s2m;

    int checks = 0;
    int errors = 0;
    int wbeats = 0;
    int b0;

    always #5 clk = ~clk;

    axi4lite_master_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi_o(m2s), .m_axi_i(s2m)
    );

    always @(posedge clk) if (m2s.wvalid && s2m.wready) wbeats <= wbeats + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        s2m = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_m2s", m2s, 0);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Read, zero-wait slave
        issue(1'b0, 32'h100, 32'h0, 4'h0);
        @(negedge clk); req_valid = 1'b0;
        chk("rd_arvalid", m2s.arvalid, 1);
        chk("rd_araddr", m2s.araddr, 32'h100);
        chk("rd_busy", req_ready, 0);
        s2m.arready = 1'b1;
        @(negedge clk); s2m.arready = 1'b0;
        chk("rd_ar_drop", m2s.arvalid, 0);
        chk("rd_rready", m2s.rready, 1);
        chk("rd_no_resp", resp_valid, 0);
        s2m.rvalid = 1'b1; s2m.rdata = 32'hDEADBEEF; s2m.rresp = 2'b00;
        @(negedge clk); s2m.rvalid = 1'b0;
        chk("rd_resp_valid", resp_valid, 1);
        chk("rd_rdata", resp_rdata, 32'hDEADBEEF);
        chk("rd_err", resp_err, 0);
        chk("rd_ready_back", req_ready, 1);
        @(negedge clk);
        chk("rd_pulse_end", resp_valid, 0);
        chk("rd_rdata_hold", resp_rdata, 32'hDEADBEEF);

        // Write, wready delayed after awready
        b0 = wbeats;
        issue(1'b1, 32'h200, 32'h12345678, 4'hF);
        @(negedge clk); req_valid = 1'b0;
        chk("wr_awvalid", m2s.awvalid, 1);
        chk("wr_wvalid", m2s.wvalid, 1);
        chk("wr_awaddr", m2s.awaddr, 32'h200);
        s2m.awready = 1'b1;
        @(negedge clk); s2m.awready = 1'b0;
        chk("wr_aw_drop", m2s.awvalid, 0);
        chk("wr_wwait_wvalid", m2s.wvalid, 1);
        @(negedge clk);
        chk("wr_wvalid_hold", m2s.wvalid, 1);
        @(negedge clk);
        chk("wr_wdata", m2s.wdata, 32'h12345678);
        chk("wr_wstrb", m2s.wstrb, 4'hF);
        s2m.wready = 1'b1;
        @(negedge clk); s2m.wready = 1'b0;
        chk("wr_bready", m2s.bready, 1);
        chk("wr_w_drop", m2s.wvalid, 0);
        chk("wr_one_beat", wbeats - b0, 1);
        s2m.bvalid = 1'b1; s2m.bresp = 2'b00;
        chk("wr_no_resp_in_b", resp_valid, 0);
        @(negedge clk); s2m.bvalid = 1'b0;
        chk("wr_resp_valid", resp_valid, 1);
        chk("wr_err", resp_err, 0);
        chk("wr_rdata_zero", resp_rdata, 0);

        // Write, wready two cycles before awready
        b0 = wbeats;
        issue(1'b1, 32'h300, 32'hA5A5A5A5, 4'h3);
        @(negedge clk); req_valid = 1'b0;
        chk("ew_wvalid", m2s.wvalid, 1);
        s2m.wready = 1'b1;
        @(negedge clk); s2m.wready = 1'b0;
        chk("ew_w_drop", m2s.wvalid, 0);
        chk("ew_aw_hold", m2s.awvalid, 1);
        chk("ew_one_beat", wbeats - b0, 1);
        @(negedge clk);
        chk("ew_w_still_low", m2s.wvalid, 0);
        s2m.awready = 1'b1;
        @(negedge clk); s2m.awready = 1'b0;
        chk("ew_bready", m2s.bready, 1);
        chk("ew_aw_drop", m2s.awvalid, 0);
        chk("ew_beats_final", wbeats - b0, 1);
        s2m.bvalid = 1'b1; s2m.bresp = 2'b01;
        @(negedge clk); s2m.bvalid = 1'b0;
        chk("ew_resp_valid", resp_valid, 1);
        chk("ew_exokay_ok", resp_err, 0);

        // DECERR read, then back-to-back SLVERR write
        issue(1'b0, 32'h400, 32'h0, 4'h0);
        @(negedge clk); req_valid = 1'b0; s2m.arready = 1'b1;
        @(negedge clk); s2m.arready = 1'b0;
        s2m.rvalid = 1'b1; s2m.rdata = 32'h11111111; s2m.rresp = 2'b11;
        @(negedge clk); s2m.rvalid = 1'b0;
        chk("de_resp_valid", resp_valid, 1);
        chk("de_err", resp_err, 1);
        chk("de_rdata", resp_rdata, 32'h11111111);
        chk("b2b_ready", req_ready, 1);
        issue(1'b1, 32'h500, 32'h0, 4'h1);
        @(negedge clk); req_valid = 1'b0;
        chk("b2b_awvalid", m2s.awvalid, 1);
        chk("b2b_pulse_end", resp_valid, 0);
        chk("b2b_err_hold", resp_err, 1);
        s2m.awready = 1'b1; s2m.wready = 1'b1;
        @(negedge clk); s2m.awready = 1'b0; s2m.wready = 1'b0;
        chk("se_bready", m2s.bready, 1);
        s2m.bvalid = 1'b1; s2m.bresp = 2'b10;
        @(negedge clk); s2m.bvalid = 1'b0;
        chk("se_resp_valid", resp_valid, 1);
        chk("se_err", resp_err, 1);
        chk("se_rdata_zero", resp_rdata, 0);

        // Reset while in R_WAIT
        issue(1'b0, 32'h600, 32'h0, 4'h0);
        @(negedge clk); req_valid = 1'b0; s2m.arready = 1'b1;
        @(negedge clk); s2m.arready = 1'b0;
        chk("rs_rready_pre", m2s.rready, 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rs_rready", m2s.rready, 0);
        chk("rs_idle", req_ready, 1);
        chk("rs_no_resp", resp_valid, 0);
        @(negedge clk);
        chk("rs_no_resp2", resp_valid, 0);
        chk("rs_m2s_quiet", m2s.arvalid | m2s.awvalid | m2s.wvalid, 0);

        // Misaligned read
        issue(1'b0, 32'h102, 32'h0, 4'h0);
        @(negedge clk); req_valid = 1'b0;
`ifdef AXI_ALIGN_CHECK_EN
        chk("al_no_arvalid", m2s.arvalid, 0);
        chk("al_resp_valid", resp_valid, 1);
        chk("al_err", resp_err, 1);
        chk("al_rdata", resp_rdata, 0);
        chk("al_ready_low", req_ready, 0);
        @(negedge clk);
        chk("al_ready_back", req_ready, 1);
        chk("al_still_quiet", m2s.arvalid, 0);
`else
        chk("na_arvalid", m2s.arvalid, 1);
        chk("na_araddr", m2s.araddr, 32'h102);
        s2m.arready = 1'b1;
        @(negedge clk); s2m.arready = 1'b0;
        s2m.rvalid = 1'b1; s2m.rdata = 32'h0BADF00D; s2m.rresp = 2'b00;
        @(negedge clk); s2m.rvalid = 1'b0;
        chk("na_resp_valid", resp_valid, 1);
        chk("na_rdata", resp_rdata, 32'h0BADF00D);
        chk("na_err", resp_err, 0);
`endif
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
